// File: rtl/config_stream_loader_if.sv
// -----------------------------------------------------------------------------
// config_stream_loader_if
// Word-fetch handshake between an upstream configuration buffer and the
// config_stream_loader.
//
// Signals:
//   word_in    [WORD_W] configuration word offered by the buffer
//   word_valid           word_in is valid
//   word_ready           loader accepts word_in this cycle
//
// Modports:
//   master : upstream buffer (drives word_in / word_valid)
//   slave  : loader          (drives word_ready)
// -----------------------------------------------------------------------------
interface config_stream_loader_if #(
   parameter int WORD_W = 32
) ();

   logic [WORD_W-1:0] word_in;
   logic              word_valid;
   logic              word_ready;

   modport master (
      output word_in,
      output word_valid,
      input  word_ready
   );

   modport slave (
      input  word_in,
      input  word_valid,
      output word_ready
   );

endinterface

// File: rtl/config_stream_loader.sv
// -----------------------------------------------------------------------------
// config_stream_loader
// Serialises a PE block configuration bitstream into the block's config_in
// scan chain. Words are fetched from an upstream buffer over a valid/ready
// handshake and shifted out LSB first, one bit per cycle, with a shift strobe
// the chain uses as its clock enable. Exactly CHAIN_LEN bits are shifted per
// load; leftover upper bits of the final word are dropped. A one-cycle done
// pulse closes every completed load.
//
// Parameters:
//   WORD_W    width of fetched configuration words
//   CHAIN_LEN total bits in the downstream chain (>= 1)
//   CNT_W     bit counter width, 2**CNT_W > CHAIN_LEN
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset, overrides everything
//   start         one-cycle load request, honoured only when idle
//   word_if       slave side of the word-fetch handshake
//   config_bit    serial bit to the chain's config_in
//   config_shift  chain shift enable, high on every cycle a bit is presented
//   busy          high whenever a load is in progress (incl. done cycle)
//   done          one-cycle pulse after the last bit
//   bits_sent     bits shifted in the current or most recent load
// -----------------------------------------------------------------------------
module config_stream_loader #(
   parameter int WORD_W    = 32,
   parameter int CHAIN_LEN = 37,
   parameter int CNT_W     = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   config_stream_loader_if.slave  word_if,
   output logic                   config_bit,
   output logic                   config_shift,
   output logic                   busy,
   output logic                   done,
   output logic [CNT_W-1:0]       bits_sent
);

   // In-word counter must be able to hold the value WORD_W itself.
   localparam int WC_W = $clog2(WORD_W + 1);

   localparam logic [CNT_W-1:0] LP_CHAIN_LEN = CNT_W'(CHAIN_LEN);
   localparam logic [WC_W-1:0]  LP_WORD_W    = WC_W'(WORD_W);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic [WORD_W-1:0]   r_shreg;
   logic [WORD_W-1:0]   w_shreg_next;
   logic [WC_W-1:0]     r_word_cnt;
   logic [WC_W-1:0]     w_word_cnt_next;
   logic [WC_W-1:0]     w_word_cnt_inc;
   logic [CNT_W-1:0]    r_bits_sent;
   logic [CNT_W-1:0]    w_bits_sent_next;
   logic [CNT_W-1:0]    w_bits_sent_inc;

   logic                r_config_bit;
   logic                r_config_shift;
   logic                r_done;

   assign w_word_cnt_inc  = r_word_cnt + WC_W'(1);
   assign w_bits_sent_inc = r_bits_sent + CNT_W'(1);

   // -------------------------------------------------------------------------
   // Next-state / datapath decode
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_next     = r_state;
      w_shreg_next     = r_shreg;
      w_word_cnt_next  = r_word_cnt;
      w_bits_sent_next = r_bits_sent;

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next     = ST_FETCH;
               w_bits_sent_next = '0;
            end
         end

         ST_FETCH: begin
            // word_ready is a pure function of state, so the handshake
            // completes whenever the buffer offers a word here.
            if (word_if.word_valid) begin
               w_shreg_next    = word_if.word_in;
               w_word_cnt_next = '0;
               w_state_next    = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            w_shreg_next     = r_shreg >> 1;
            w_word_cnt_next  = w_word_cnt_inc;
            w_bits_sent_next = w_bits_sent_inc;
            // Chain end is tested first: when the chain length is an exact
            // multiple of WORD_W the load must finish rather than fetch a
            // word that will never be shifted.
            if (w_bits_sent_inc == LP_CHAIN_LEN) begin
               w_state_next = ST_DONE;
            end else if (w_word_cnt_inc == LP_WORD_W) begin
               w_state_next = ST_FETCH;
            end
         end

         ST_DONE: begin
            w_state_next = ST_IDLE;
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_shreg        <= '0;
         r_word_cnt     <= '0;
         r_bits_sent    <= '0;
         r_config_bit   <= 1'b0;
         r_config_shift <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_shreg        <= w_shreg_next;
         r_word_cnt     <= w_word_cnt_next;
         r_bits_sent    <= w_bits_sent_next;
         // Chain-facing outputs come straight from flops so the shift enable
         // is glitch-free. They are loaded from the values the datapath takes
         // on the same edge, so during a SHIFT cycle config_bit equals the
         // current shift register LSB.
         r_config_shift <= (w_state_next == ST_SHIFT);
         r_config_bit   <= (w_state_next == ST_SHIFT) ? w_shreg_next[0] : 1'b0;
         r_done         <= (w_state_next == ST_DONE);
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign word_if.word_ready = (r_state == ST_FETCH);
   assign busy               = (r_state != ST_IDLE);
   assign config_bit         = r_config_bit;
   assign config_shift       = r_config_shift;
   assign done               = r_done;
   assign bits_sent          = r_bits_sent;

endmodule

// File: tb/tb_config_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_config_stream_loader
// Two loaders: dut0 with a 37-bit chain (two words per load) and dut1 with a
// 32-bit chain (exactly one word). A reference model reasons only about the
// bit stream (bits queued from accepted words, bits already shifted) and a
// compare process checks every output of both loaders on every falling edge.
// Directed loads add literal expectations for timing, word counts and the
// captured serial stream.
// -----------------------------------------------------------------------------
module tb_config_stream_loader;

   localparam int WORD_W = 32;
   localparam int CNT_W  = 16;
   localparam int CL0    = 37;
   localparam int CL1    = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset;
   logic             start0, start1;
   logic             cb0, cs0, busy0, done0;
   logic             cb1, cs1, busy1, done1;
   logic [CNT_W-1:0] bs0, bs1;

   config_stream_loader_if #(.WORD_W(WORD_W)) if0 ();
   config_stream_loader_if #(.WORD_W(WORD_W)) if1 ();

   config_stream_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CL0), .CNT_W(CNT_W)) dut0 (
      .clk          (clk),
      .reset        (reset),
      .start        (start0),
      .word_if      (if0.slave),
      .config_bit   (cb0),
      .config_shift (cs0),
      .busy         (busy0),
      .done         (done0),
      .bits_sent    (bs0)
   );

   config_stream_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CL1), .CNT_W(CNT_W)) dut1 (
      .clk          (clk),
      .reset        (reset),
      .start        (start1),
      .word_if      (if1.slave),
      .config_bit   (cb1),
      .config_shift (cs1),
      .busy         (busy1),
      .done         (done1),
      .bits_sent    (bs1)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: per loader, a stream of bits taken from accepted words
   // (never more than the chain still needs) and a count of bits shifted.
   // ---------------------------------------------------------------------------
   int m_cl   [2];
   bit m_busy [2];
   bit m_done [2];
   int m_sent [2];
   int m_wr   [2];
   int m_rd   [2];
   bit m_bits [2][128];

   initial begin
      m_cl[0] = CL0;
      m_cl[1] = CL1;
      for (int i = 0; i < 2; i++) begin
         m_busy[i] = 0; m_done[i] = 0; m_sent[i] = 0; m_wr[i] = 0; m_rd[i] = 0;
      end
      forever begin
         logic              st [2];
         logic              v  [2];
         logic [WORD_W-1:0] w  [2];
         @(posedge clk);
         st[0] = start0;  v[0] = if0.word_valid;  w[0] = if0.word_in;
         st[1] = start1;  v[1] = if1.word_valid;  w[1] = if1.word_in;
         for (int i = 0; i < 2; i++) begin
            if (reset) begin
               m_busy[i] = 0; m_done[i] = 0; m_sent[i] = 0; m_wr[i] = 0; m_rd[i] = 0;
            end else if (m_done[i]) begin
               m_done[i] = 0;
               m_busy[i] = 0;
            end else if (!m_busy[i]) begin
               if (st[i]) begin
                  m_busy[i] = 1; m_sent[i] = 0; m_wr[i] = 0; m_rd[i] = 0;
               end
            end else if (m_wr[i] == m_rd[i]) begin
               if (v[i]) begin
                  int n;
                  n = m_cl[i] - m_sent[i];
                  if (n > WORD_W) n = WORD_W;
                  for (int k = 0; k < n; k++) m_bits[i][m_wr[i] + k] = w[i][k];
                  m_wr[i] = m_wr[i] + n;
               end
            end else begin
               m_rd[i]   = m_rd[i] + 1;
               m_sent[i] = m_sent[i] + 1;
               if (m_sent[i] == m_cl[i]) m_done[i] = 1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Compare process + stream capture / word counting for the literal checks
   // ---------------------------------------------------------------------------
   bit cap [64];
   int cap_n  = 0;
   int words0 = 0;
   int words1 = 0;

   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            logic             a_rdy, a_shift, a_bit, a_busy, a_done;
            logic [CNT_W-1:0] a_bs;
            bit               e_active, e_shift, e_bit;
            if (i == 0) begin
               a_rdy = if0.word_ready; a_shift = cs0; a_bit = cb0;
               a_busy = busy0; a_done = done0; a_bs = bs0;
            end else begin
               a_rdy = if1.word_ready; a_shift = cs1; a_bit = cb1;
               a_busy = busy1; a_done = done1; a_bs = bs1;
            end
            e_active = m_busy[i] && !m_done[i];
            e_shift  = e_active && (m_wr[i] != m_rd[i]);
            e_bit    = e_shift ? m_bits[i][m_rd[i]] : 1'b0;
            chk($sformatf("d%0d_word_ready", i), {31'd0, a_rdy},
                {31'd0, e_active && (m_wr[i] == m_rd[i])});
            chk($sformatf("d%0d_config_shift", i), {31'd0, a_shift}, {31'd0, e_shift});
            chk($sformatf("d%0d_config_bit", i), {31'd0, a_bit}, {31'd0, e_bit});
            chk($sformatf("d%0d_busy", i), {31'd0, a_busy}, {31'd0, m_busy[i]});
            chk($sformatf("d%0d_done", i), {31'd0, a_done}, {31'd0, m_done[i]});
            chk($sformatf("d%0d_bits_sent", i), {16'd0, a_bs}, m_sent[i]);
         end
         if (cs0 && cap_n < 64) begin
            cap[cap_n] = cb0;
            cap_n++;
         end
         if (if0.word_valid && if0.word_ready) words0++;
         if (if1.word_valid && if1.word_ready) words1++;
      end
   end

   // ---------------------------------------------------------------------------
   // Upstream buffer for dut0: presents words in order, optionally withholding
   // a word for a number of cycles the loader spends waiting in fetch.
   // ---------------------------------------------------------------------------
   logic [WORD_W-1:0] f_words [4];
   int                f_stall_tab [4];
   int                f_idx   = 0;
   int                f_stall = 0;

   initial begin
      forever begin
         bit take, rdy;
         @(negedge clk);
         take = if0.word_valid && if0.word_ready;
         rdy  = if0.word_ready;
         @(posedge clk);
         #1;
         if (take) begin
            if (f_idx < 3) f_idx++;
            f_stall = f_stall_tab[f_idx];
         end else if (rdy && f_stall > 0) begin
            f_stall--;
         end
         if0.word_valid = (f_stall == 0);
         if0.word_in    = f_words[f_idx];
      end
   end

   int t_start = 0;

   // Starts a dut0 load: start is high for the cycle numbered 0.
   task automatic load0(input logic [31:0] w0, input logic [31:0] w1, input int stall1);
      @(posedge clk);
      #2;
      f_words[0] = w0;  f_words[1] = w1;  f_words[2] = 32'h0;  f_words[3] = 32'h0;
      f_stall_tab[0] = 0;  f_stall_tab[1] = stall1;  f_stall_tab[2] = 0;  f_stall_tab[3] = 0;
      f_idx = 0;
      f_stall = 0;
      if0.word_valid = 1'b1;
      if0.word_in    = w0;
      start0  = 1'b1;
      t_start = cyc;
      cap_n   = 0;
      words0  = 0;
      @(posedge clk);
      #2;
      start0 = 1'b0;
   endtask

   task automatic wait_done0(output int dcyc);
      dcyc = -1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (done0) begin
            dcyc = cyc - t_start;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL d0_done_timeout actual=none required=done within 300 cycles");
   endtask

   function automatic logic [31:0] cap_word(input int base, input int n);
      logic [31:0] r;
      r = '0;
      for (int k = 0; k < n; k++) r[k] = cap[base + k];
      return r;
   endfunction

   initial begin
      int d;
      reset  = 1'b1;
      start0 = 1'b0;
      start1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         f_words[k] = 32'hDEAD_BEEF;
         f_stall_tab[k] = 0;
      end
      if0.word_valid = 1'b1;
      if0.word_in    = 32'hDEAD_BEEF;
      if1.word_valid = 1'b1;
      if1.word_in    = 32'h1234_5678;

      // Reset with a valid word offered: nothing may be accepted.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_word_ready", {31'd0, if0.word_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy0}, 32'd0);
      chk("rst_bits_sent", {16'd0, bs0}, 32'd0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      repeat (3) @(posedge clk);

      // Basic two-word load.
      load0(32'hA5A5_0F0F, 32'hFFFF_FFF3, 0);
      wait_done0(d);
      chk("basic_done_cycle", d, 32'd40);
      chk("basic_words", words0, 32'd2);
      chk("basic_bits_sent", {16'd0, bs0}, 32'd37);
      chk("basic_nbits", cap_n, 32'd37);
      chk("basic_stream_word0", cap_word(0, 32), 32'hA5A5_0F0F);
      chk("basic_stream_tail", cap_word(32, 5), 32'h13);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("hold_bits_sent", {16'd0, bs0}, 32'd37);

      // Second word withheld for 5 fetch cycles.
      load0(32'hA5A5_0F0F, 32'hFFFF_FFF3, 5);
      wait_done0(d);
      chk("stall_done_cycle", d, 32'd45);
      chk("stall_words", words0, 32'd2);
      chk("stall_stream_word0", cap_word(0, 32), 32'hA5A5_0F0F);
      chk("stall_stream_tail", cap_word(32, 5), 32'h13);

      // Exact-multiple chain on dut1: one word, no second fetch.
      @(posedge clk);
      #2;
      start1  = 1'b1;
      t_start = cyc;
      words1  = 0;
      @(posedge clk);
      #2;
      start1 = 1'b0;
      d = -1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (done1) begin
            d = cyc - t_start;
            break;
         end
      end
      chk("exact_done_cycle", d, 32'd34);
      chk("exact_words", words1, 32'd1);
      chk("exact_bits_sent", {16'd0, bs1}, 32'd32);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("exact_words_after", words1, 32'd1);

      // Starts during a load and in its done cycle are ignored.
      load0(32'h0123_4567, 32'h0000_001A, 0);
      repeat (9) @(posedge clk);
      #2;
      start0 = 1'b1;
      @(posedge clk);
      #2;
      start0 = 1'b0;
      wait_done0(d);
      chk("ignstart_done_cycle", d, 32'd40);
      chk("ignstart_words", words0, 32'd2);
      chk("ignstart_stream_tail", cap_word(32, 5), 32'h1A);
      start0 = 1'b1;          // asserted in the done cycle
      @(posedge clk);
      #2;                      // now idle: this cycle's start is accepted
      f_idx = 0;
      f_stall = 0;
      if0.word_valid = 1'b1;
      if0.word_in    = f_words[0];
      t_start = cyc;
      cap_n   = 0;
      words0  = 0;
      @(posedge clk);
      #2;
      start0 = 1'b0;
      wait_done0(d);
      chk("restart_done_cycle", d, 32'd40);
      chk("restart_words", words0, 32'd2);
      chk("restart_stream_word0", cap_word(0, 32), 32'h0123_4567);

      // Reset part way through the first word.
      load0(32'hA5A5_0F0F, 32'hFFFF_FFF3, 0);
      d = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bs0 == 16'd20) begin
            d = 1;
            break;
         end
      end
      chk("midrst_reached_20", d, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #2;
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_busy", {31'd0, busy0}, 32'd0);
      chk("midrst_shift", {31'd0, cs0}, 32'd0);
      chk("midrst_done", {31'd0, done0}, 32'd0);
      chk("midrst_bits_sent", {16'd0, bs0}, 32'd0);
      chk("midrst_word_ready", {31'd0, if0.word_ready}, 32'd0);
      repeat (5) @(posedge clk);
      load0(32'hA5A5_0F0F, 32'hFFFF_FFF3, 0);
      wait_done0(d);
      chk("reload_done_cycle", d, 32'd40);
      chk("reload_nbits", cap_n, 32'd37);
      chk("reload_stream_word0", cap_word(0, 32), 32'hA5A5_0F0F);
      chk("reload_stream_tail", cap_word(32, 5), 32'h13);

      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/config_stream_loader.md
Name: config_stream_loader

Overview:
Serialises a PE block's configuration bitstream into the block's config_in scan chain. It fetches WORD_W-bit words from an upstream config buffer over a valid/ready handshake. It then shifts exactly CHAIN_LEN bits out, LSB first, one bit per cycle, with a per-bit shift strobe that the chain uses as its clock enable. It sits directly upstream of a PE block's config_in/config_clk chain and finishes with a one-cycle done pulse.

Parameters:
WORD_W, 32, width of fetched configuration words.
CHAIN_LEN, 37, total bits in the downstream config chain (≥1).
CNT_W, 16, width of the bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin a load; ignored unless in IDLE.
word_in  input  WORD_W  configuration word from upstream buffer.
word_valid  input  1  word_in is valid.
word_ready  output  1  loader accepts word_in this cycle.
config_bit  output  1  serial bit presented to the chain's config_in.
config_shift  output  1  chain shift enable; high exactly on cycles where config_bit is to be captured.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse after the last bit is shifted.
bits_sent  output  CNT_W  bits shifted in the current or last load.

Behaviour:
- Reset (synchronous, priority over everything): state=IDLE; word_ready=0, config_bit=0, config_shift=0, busy=0, done=0, bits_sent=0; shift register cleared.
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE:
  - start=1 → FETCH next cycle; bits_sent cleared to 0 on that edge.
  - start=0 → remain in IDLE.
- FETCH:
  - word_ready=1 (combinational from state only, never from word_valid).
  - On word_valid&word_ready: capture word_in into the shift register, clear the in-word counter, go to SHIFT.
  - word_valid=0 → stay in FETCH indefinitely; config_shift=0.
- SHIFT (registered outputs):
  - Each cycle: config_bit = shreg[0], config_shift=1. On the edge: shreg >>= 1, in-word count +1, bits_sent +1.
  - If bits_sent+1 == CHAIN_LEN → DONE.
  - Else if in-word count+1 == WORD_W → FETCH.
  - Else stay in SHIFT.
  - End-of-chain takes priority over end-of-word when both occur together.
- DONE: done=1, busy=1, config_shift=0 for exactly one cycle, then IDLE.
- Outside SHIFT: config_shift=0 and config_bit=0.
- Words consumed per load = ceil(CHAIN_LEN/WORD_W). Unused upper bits of the final word (WORD_W·words − CHAIN_LEN) are discarded, never shifted.
- Bit order: bit 0 of word 0 is shifted first and ends deepest in the chain (farthest from config_in).
- Latency with word_valid held high, first word: start → FETCH (cycle 1) → handshake → first config_shift (cycle 2).
- Each later word adds one FETCH cycle (one bubble with config_shift=0).
- Total cycles start→done = CHAIN_LEN + words + 1, with done in the final cycle.
- start while busy: ignored, no effect on the ongoing load.
- start in the same cycle as done: ignored. A new start is accepted from IDLE, i.e. the cycle after done at the earliest.
- Reset mid-load: abort immediately, no done pulse. The partial chain contents are the upstream's concern; the loader re-shifts the full chain on the next start.
- word_valid while not in FETCH: ignored, word not consumed.
- bits_sent holds its final value (CHAIN_LEN) after done until the next accepted start.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, word_valid=1 → word_ready=0, config_shift=0, busy=0, done=0, bits_sent=0 throughout.
- Basic load, CHAIN_LEN=37, WORD_W=32:
  - Stimulus: start, word0=0xA5A5_0F0F, word1=0xFFFF_FFF3, both immediately valid.
  - Serial stream: 32 bits of 0x A5A50F0F LSB first, one bubble, then bits 1,1,0,0,1.
  - done at cycle 37+2+1=40 after start; exactly 2 words accepted; bits_sent=37.
- Stalled upstream: word_valid low for 5 cycles in FETCH before word1 → loader stays in FETCH with config_shift=0 for those cycles; stream content unchanged; done delayed by exactly 5 cycles.
- Exact-multiple boundary: CHAIN_LEN=32 → one word consumed; transition goes SHIFT→DONE, never back to FETCH; done at cycle 34.
- Ignored start: pulse start at cycle 10 of a load and again in the done cycle → no restart, no extra word_ready; a start one cycle after done begins a new load normally.
- Reset mid-shift: assert reset at bits_sent=20 → next cycle all outputs 0 and state IDLE, no done pulse; a following start reloads all 37 bits from word 0.
